stack_seq_ctrl: RTL

- Multi-cycle sequencer for the stack-machine datapath; replaces single-cycle decode with a FETCH/DECODE/MEM/EXEC FSM.
- Handshakes with instruction memory and data memory using req/ready, and owns the stack pointer.
- Detects stack overflow/underflow before any state is committed.
- Drives the existing datapath control encodings: ALUOp, PCSrc, StackWriteSrc, ALUSrc.

---
 rtl/stack_seq_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/stack_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the stack-machine datapath.
// Owns the stack pointer and traps stack over/underflow before anything commits.
module stack_seq_ctrl #(
    parameter int STACK_DEPTH = 16,
    parameter int SP_W        = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            branch_taken,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSrc,
    output logic [1:0]      StackWriteSrc,
    output logic            ALUSrc,
    output logic            ir_write,
    output logic            pc_write,
    output logic            stack_we,
    output logic [SP_W-1:0] sp,
    output logic            fault,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_MEM    = 2'b10,
        S_EXEC   = 2'b11
    } state_t;

    localparam logic [SP_W:0] DEPTH_EXT = (SP_W+1)'(STACK_DEPTH);

    state_t          state_q, state_d;
    logic            fault_q, fault_d;
    logic [5:0]      ir_q, ir_d;
    logic [SP_W-1:0] sp_q, sp_d;

    logic [2:0]      op1;
    logic [2:0]      op2;
    logic [1:0]      need;
    logic            net_inc;
    logic            net_dec;
    logic [SP_W:0]   sp_ext;
    logic            stack_err;
    logic            unused_instr_bits;

    // Only the two opcode fields steer the sequencer; operand bits live in the datapath IR.
    assign unused_instr_bits = ^instr_in[25:0];
    assign op1    = ir_q[5:3];
    assign op2    = ir_q[2:0];
    assign sp_ext = {1'b0, sp_q};

    always_comb begin
        need    = 2'd0;
        net_inc = 1'b0;
        net_dec = 1'b0;
        case (op1)
            3'b000: begin
                if (op2 == 3'b010) begin
                    need = 2'd1;
                end else begin
                    need    = 2'd2;
                    net_dec = 1'b1;
                end
            end
            3'b001:  need = 2'd1;
            3'b010:  net_inc = 1'b1;
            3'b100:  begin need = 2'd2; net_dec = 1'b1; end
            3'b110:  net_inc = 1'b1;
            default: begin need = 2'd1; net_dec = 1'b1; end // pop, branch, pop_pc
        endcase
    end

    // Extended width keeps sp+1 from wrapping at full depth.
    assign stack_err = (sp_ext < {{(SP_W-1){1'b0}}, need}) ||
                       (net_inc && ((sp_ext + 1'b1) > DEPTH_EXT));

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        ir_d    = ir_q;
        sp_d    = sp_q;
        if (!fault_q) begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_d    = instr_in[31:26];
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (stack_err) begin
                        fault_d = 1'b1;
                    end else if (op1 == 3'b010 || op1 == 3'b011) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_d = S_EXEC;
                    end
                end
                default: begin
                    if (net_inc) begin
                        sp_d = sp_q + 1'b1;
                    end else if (net_dec) begin
                        sp_d = sp_q - 1'b1;
                    end
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
            ir_q    <= 6'd0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            ir_q    <= ir_d;
            sp_q    <= sp_d;
        end
    end

    // Outputs decode registered state/IR; reset and fault silence every strobe.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        ALUOp         = 2'b00;
        PCSrc         = 2'b00;
        StackWriteSrc = 2'b00;
        ALUSrc        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        if (!reset && !fault_q) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    MemRead  = (op1 == 3'b010);
                    MemWrite = (op1 == 3'b011);
                end
                S_EXEC: begin
                    pc_write = 1'b1;
                    case (op1)
                        3'b000:  begin ALUOp = 2'b01; StackWriteSrc = 2'b01; end
                        3'b001:  begin ALUOp = 2'b01; ALUSrc = 1'b1; StackWriteSrc = 2'b01; end
                        3'b010:  begin StackWriteSrc = 2'b10; MemRead = 1'b1; end
                        3'b100:  begin ALUOp = 2'b10; StackWriteSrc = 2'b01; end
                        3'b101:  begin ALUOp = 2'b10; PCSrc = branch_taken ? 2'b01 : 2'b00; end
                        3'b110:  StackWriteSrc = 2'b11;
                        3'b111:  PCSrc = 2'b10;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign stack_we = (StackWriteSrc != 2'b00);
    assign sp       = sp_q;
    assign fault    = fault_q;
    assign state    = fault_q ? 2'b01 : state_q;

endmodule
